systolic_feeder: RTL and testbench



---
 rtl/systolic_feeder_pkg.sv | 22 ++
 rtl/skew_lane_mux.sv | 25 ++
 rtl/systolic_feeder.sv | 143 ++++++++++++++
 tb/tb_systolic_feeder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_feeder_pkg.sv
// Shared constants, state encoding and counter-width helpers for the systolic feeder.
package systolic_feeder_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // Row counter spans 0..N-1.
    function automatic int row_w(input int n);
        return $clog2(n);
    endfunction

    // Stream step counter spans 0..2N-2.
    function automatic int step_w(input int n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/skew_lane_mux.sv
// One skewed lane: picks line[t - LANE] when that index lies inside the matrix, else zero.
module skew_lane_mux
    import systolic_feeder_pkg::*;
#(
    parameter int N    = 32,
    parameter int LANE = 0
) (
    input  logic [BYTE_W-1:0]      line [N],
    input  logic [step_w(N)-1:0]   t,
    output logic [BYTE_W-1:0]      lane_byte
);

    localparam int TW = step_w(N);
    localparam int RW = row_w(N);

    logic signed [TW:0] diff;
    logic               in_range;

    // One extra bit keeps t - LANE signed, so early lanes see a negative index instead of wrapping.
    assign diff     = $signed({1'b0, t}) - $signed((TW+1)'(LANE));
    assign in_range = !diff[TW] && (diff <= $signed((TW+1)'(N - 1)));

    assign lane_byte = in_range ? line[diff[RW-1:0]] : '0;

endmodule

// File: rtl/systolic_feeder.sv
// Loads A and B row by row, streams them diagonally skewed into the array, then waits out the readout.
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [BYTE_W*N-1:0]   ld_a,
    input  logic [BYTE_W*N-1:0]   ld_b,
    output logic [BYTE_W*N-1:0]   in_a,
    output logic [BYTE_W*N-1:0]   in_b,
    output logic                  en_in,
    input  logic                  en_out,
    output logic                  busy
);

    localparam int RW = row_w(N);
    localparam int TW = step_w(N);

    state_t          state, next_state;
    logic [RW-1:0]   r, next_r;
    logic [TW-1:0]   t, next_t;
    logic            seen, next_seen;
    logic            accept;

    logic [BYTE_W-1:0] a_mem [N][N];
    logic [BYTE_W-1:0] b_mem [N][N];
    logic [BYTE_W-1:0] lane_a [N];
    logic [BYTE_W-1:0] lane_b [N];

    logic                ld_ready_d, en_in_d, busy_d;
    logic [BYTE_W*N-1:0] in_a_d, in_b_d;

    assign accept = (state == LOAD) && ld_valid && ld_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
            r     <= '0;
            t     <= '0;
            seen  <= 1'b0;
        end else begin
            state <= next_state;
            r     <= next_r;
            t     <= next_t;
            seen  <= next_seen;
        end
    end

    always_comb begin
        next_state = state;
        next_r     = r;
        next_t     = t;
        next_seen  = seen;
        case (state)
            LOAD: begin
                if (accept) begin
                    if (r == RW'(N - 1)) begin
                        next_state = STREAM;
                        next_r     = '0;
                        next_t     = '0;
                    end else begin
                        next_r = r + RW'(1);
                    end
                end
            end
            STREAM: begin
                next_seen = 1'b0;
                if (t == TW'(2 * N - 2)) begin
                    next_state = DRAIN;
                    next_t     = '0;
                end else begin
                    next_t = t + TW'(1);
                end
            end
            DRAIN: begin
                // Leave only once the readout pulse has been seen high and then low.
                if (en_out) begin
                    next_seen = 1'b1;
                end else if (seen) begin
                    next_state = LOAD;
                    next_r     = '0;
                end
            end
            default: next_state = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < N; k++) begin
                a_mem[r][k] <= ld_a[BYTE_W*k +: BYTE_W];
                b_mem[r][k] <= ld_b[BYTE_W*k +: BYTE_W];
            end
        end
    end

    // Lanes are evaluated at next_t so the skewed bytes land in the output registers with the step.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [BYTE_W-1:0] a_line [N];
        logic [BYTE_W-1:0] b_line [N];
        for (genvar k = 0; k < N; k++) begin : g_tap
            assign a_line[k] = a_mem[i][k];
            assign b_line[k] = b_mem[k][i];
        end
        skew_lane_mux #(.N(N), .LANE(i)) u_a (.line(a_line), .t(next_t), .lane_byte(lane_a[i]));
        skew_lane_mux #(.N(N), .LANE(i)) u_b (.line(b_line), .t(next_t), .lane_byte(lane_b[i]));
    end

    always_comb begin
        ld_ready_d = (next_state == LOAD);
        busy_d     = (next_state != LOAD);
        en_in_d    = (state == LOAD) && (next_state == STREAM);
        in_a_d     = '0;
        in_b_d     = '0;
        if (next_state == STREAM) begin
            for (int i = 0; i < N; i++) begin
                in_a_d[BYTE_W*i +: BYTE_W] = lane_a[i];
                in_b_d[BYTE_W*i +: BYTE_W] = lane_b[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_ready <= 1'b0;
            busy     <= 1'b0;
            en_in    <= 1'b0;
            in_a     <= '0;
            in_b     <= '0;
        end else begin
            ld_ready <= ld_ready_d;
            busy     <= busy_d;
            en_in    <= en_in_d;
            in_a     <= in_a_d;
            in_b     <= in_b_d;
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: matrix-level reference model, per-cycle compare, randomized loads and readouts.
module tb_systolic_feeder;

    localparam int N = 4;
    localparam int W = 8 * N;

    logic         clk = 1'b0;
    logic         reset;
    logic         ld_valid;
    logic         ld_ready;
    logic [W-1:0] ld_a, ld_b;
    logic [W-1:0] in_a, in_b;
    logic         en_in;
    logic         en_out;
    logic         busy;

    systolic_feeder #(.N(N)) dut (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_a(ld_a), .ld_b(ld_b), .in_a(in_a), .in_b(in_b),
        .en_in(en_in), .en_out(en_out), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Matrices the driver presents; model copies what it believes was accepted.
    logic [7:0] pa [N][N];
    logic [7:0] pb [N][N];
    logic [7:0] ma [N][N];
    logic [7:0] mb [N][N];

    int         mph = 0;
    int         mrow = 0;
    int         mt = 0;
    bit         mseen = 0;
    bit         exp_ready, exp_en, exp_busy;
    logic [W-1:0] exp_a, exp_b;

    bit  cmp_on = 0;
    bit  drv_on = 0;
    int  vmode = 0;
    int  dly = 11;
    int  len = 4;

    function automatic logic [W-1:0] skew_a(input int t);
        logic [W-1:0] v = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) v[8*i +: 8] = ma[i][t-i];
        return v;
    endfunction

    function automatic logic [W-1:0] skew_b(input int t);
        logic [W-1:0] v = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) v[8*j +: 8] = mb[t-j][j];
        return v;
    endfunction

    // Reference model: phase 0 = collecting rows, 1 = streaming step mt, 2 = waiting for readout.
    initial forever begin
        @(posedge clk);
        if (reset) begin
            mph = 0; mrow = 0; mt = 0; mseen = 0;
            exp_ready = 0; exp_en = 0; exp_busy = 0; exp_a = '0; exp_b = '0;
        end else begin
            case (mph)
                0: begin
                    if (ld_valid && exp_ready) begin
                        for (int k = 0; k < N; k++) begin
                            ma[mrow][k] = ld_a[8*k +: 8];
                            mb[mrow][k] = ld_b[8*k +: 8];
                        end
                        mrow++;
                    end
                    if (mrow == N) begin
                        mph = 1; mt = 0; mrow = 0;
                        exp_ready = 0; exp_en = 1; exp_busy = 1;
                        exp_a = skew_a(0); exp_b = skew_b(0);
                    end else begin
                        exp_ready = 1;
                    end
                end
                1: begin
                    mt++;
                    exp_en = 0;
                    if (mt == 2 * N - 1) begin
                        mph = 2; mseen = 0; exp_a = '0; exp_b = '0;
                    end else begin
                        exp_a = skew_a(mt); exp_b = skew_b(mt);
                    end
                end
                default: begin
                    if (en_out) mseen = 1;
                    else if (mseen) begin
                        mph = 0; exp_ready = 1; exp_busy = 0;
                    end
                end
            endcase
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_on) begin
            check("ld_ready", {31'd0, ld_ready}, {31'd0, exp_ready});
            check("en_in", {31'd0, en_in}, {31'd0, exp_en});
            check("busy", {31'd0, busy}, {31'd0, exp_busy});
            check("in_a", in_a, exp_a);
            check("in_b", in_b, exp_b);
        end
    end

    initial forever begin
        @(negedge clk);
        if (drv_on) begin
            int rr;
            case (vmode)
                0:       ld_valid = 1'b1;
                1:       ld_valid = ~ld_valid;
                default: ld_valid = 1'($urandom_range(0, 1));
            endcase
            rr = (mrow < N) ? mrow : 0;
            for (int k = 0; k < N; k++) begin
                ld_a[8*k +: 8] = pa[rr][k];
                ld_b[8*k +: 8] = pb[rr][k];
            end
        end
    end

    // Array stub: en_out high for len cycles starting dly cycles after each en_in.
    initial begin
        int cnt = -1;
        en_out = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cnt = -1; en_out = 1'b0;
            end else if (en_in) begin
                cnt = 0; en_out = 1'b0;
            end else if (cnt >= 0) begin
                cnt++;
                if (cnt == dly) en_out = 1'b1;
                if (cnt == dly + len) begin
                    en_out = 1'b0; cnt = -1;
                end
            end
        end
    end

    task automatic wait_en_in(input string name);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (en_in === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL %s timeout waiting for en_in got=0 expected=1", name);
    endtask

    task automatic set_known();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                pa[i][k] = 8'(4 * i + k + 1);
                pb[i][k] = (i == k) ? 8'd1 : 8'd0;
            end
    endtask

    task automatic set_random();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                pa[i][k] = 8'($urandom);
                pb[i][k] = 8'($urandom);
            end
    endtask

    task automatic check_known_stream(input string tag);
        check({tag, "_t0_a"}, in_a, 32'h0000_0001);
        check({tag, "_t0_b"}, in_b, 32'h0000_0001);
        check({tag, "_t0_en"}, {31'd0, en_in}, 32'd1);
        repeat (3) @(negedge clk);
        check({tag, "_t3_a"}, in_a, 32'h0D0A_0704);
        check({tag, "_t3_b"}, in_b, 32'h0000_0000);
        repeat (3) @(negedge clk);
        check({tag, "_t6_a"}, in_a, 32'h1000_0000);
        check({tag, "_t6_b"}, in_b, 32'h0100_0000);
    endtask

    initial begin
        reset = 1'b1; ld_valid = 1'b1; ld_a = '0; ld_b = '0;
        set_known();
        @(posedge clk);
        cmp_on = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
            check("rst_in_a", in_a, 32'd0);
            check("rst_en_in", {31'd0, en_in}, 32'd0);
        end
        reset = 1'b0;
        drv_on = 1;
        @(negedge clk);
        check("post_rst_ld_ready", {31'd0, ld_ready}, 32'd1);

        // Back-to-back load of the known matrices.
        wait_en_in("known_b2b");
        check_known_stream("b2b");
        @(negedge clk);
        check("b2b_t7_a", in_a, 32'd0);
        check("b2b_t7_busy", {31'd0, busy}, 32'd1);
        vmode = 1;

        // Same matrices loaded with gaps; also pin the drain hold timing.
        wait_en_in("known_gaps");
        set_random();
        check_known_stream("gaps");
        repeat (9) @(negedge clk);
        check("drain_hold_ready", {31'd0, ld_ready}, 32'd0);
        check("drain_hold_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("drain_done_ready", {31'd0, ld_ready}, 32'd1);
        check("drain_done_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of the stream.
        vmode = 2;
        wait_en_in("pre_reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_in_a", in_a, 32'd0);
        check("midrst_in_b", in_b, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_en_in", {31'd0, en_in}, 32'd0);
        reset = 1'b0;

        // Randomized products with varying load gaps and readout timing.
        for (int p = 0; p < 10; p++) begin
            wait_en_in("random_product");
            set_random();
            vmode = $urandom_range(0, 2);
            dly = $urandom_range(2 * N, 3 * N + 2);
            len = $urandom_range(1, N);
        end
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
